// File: rtl/user_arb_wr_req_pkg.sv
// Types shared by the user write-request arbiter and the write data mux.
// A mux command tells the data mux which source to drain and for how many bytes.
package user_arb_wr_req_pkg;

  localparam int DEST_BITS    = 4;
  localparam int LEN_BITS     = 28;
  localparam int MUX_CMD_BITS = DEST_BITS + LEN_BITS;

  typedef struct packed {
    logic [LEN_BITS-1:0]  len;
    logic [DEST_BITS-1:0] dest;
  } mux_cmd_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

  // Bit width able to index v entries, never below one bit.
  function automatic int clog2s(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/user_arb_wr_req_if.sv
// Request/command bus of the user write-request arbiter.
// slave is the arbiter's view, master is the surrounding logic's view.
interface user_arb_wr_req_if
  import user_arb_wr_req_pkg::*;
#(
  parameter int N_ID      = 4,
  parameter int REQ_BITS  = 96,
  parameter int CMD_DEPTH = 16
);

  logic [N_ID-1:0]                s_req_valid;
  logic [N_ID-1:0]                s_req_ready;
  logic [N_ID-1:0][REQ_BITS-1:0]  s_req_data;

  logic                           m_req_valid;
  logic                           m_req_ready;
  logic [REQ_BITS-1:0]            m_req_data;

  logic                           m_mux_valid;
  logic                           m_mux_ready;
  logic [MUX_CMD_BITS-1:0]        m_mux_data;

  logic [clog2s(CMD_DEPTH):0]     m_cmd_used;

  modport slave (
    input  s_req_valid, s_req_data, m_req_ready, m_mux_ready,
    output s_req_ready, m_req_valid, m_req_data, m_mux_valid, m_mux_data, m_cmd_used
  );

  modport master (
    output s_req_valid, s_req_data, m_req_ready, m_mux_ready,
    input  s_req_ready, m_req_valid, m_req_data, m_mux_valid, m_mux_data, m_cmd_used
  );

endinterface

// File: rtl/user_cmd_fifo.sv
// Synchronous FIFO with occupancy count; full blocks push even when a pop
// happens in the same cycle. Shared by the read and write request paths.
module user_cmd_fifo
  import user_arb_wr_req_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [clog2s(DEPTH):0] count
);

  localparam int AW = clog2s(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             wr_en;
  logic             rd_en;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign count    = cnt;

endmodule

// File: rtl/user_arb_wr_req.sv
// Round-robin merge of user write-request streams into one host request stream,
// queueing a {len, dest} command per request for the downstream write data mux.
module user_arb_wr_req
  import user_arb_wr_req_pkg::*;
#(
  parameter int N_ID      = 4,
  parameter int REQ_BITS  = 96,
  parameter int LEN_OFFS  = 48,
  parameter int CMD_DEPTH = 16
) (
  input  logic             aclk,
  input  logic             areset,
  user_arb_wr_req_if.slave bus
);

  logic [DEST_BITS-1:0] rr_ptr_p0;
  logic [DEST_BITS-1:0] grant_p0;
  logic [DEST_BITS-1:0] next_ptr_p0;
  logic [N_ID-1:0]      vld_sh_p0;
  logic                 any_vld_p0;
  logic                 out_free_p0;
  logic                 acc_p0;
  logic                 push_p0;
  logic [REQ_BITS-1:0]  req_word_p0;
  mux_cmd_t             cmd_p0;
  logic                 cmd_full;
  logic                 cmd_empty;

  arb_state_t           state_p1;
  logic                 vld_p1;
  logic [REQ_BITS-1:0]  req_data_p1;

  // Stage p0: round-robin grant, accept decision and command push.
  // Scanning downwards and overwriting leaves the first valid source at or after rr_ptr.
  always_comb begin
    grant_p0   = '0;
    any_vld_p0 = 1'b0;
    vld_sh_p0  = '0;
    for (int i = N_ID - 1; i >= 0; i--) begin
      vld_sh_p0 = bus.s_req_valid >> ((int'(rr_ptr_p0) + i) % N_ID);
      if (vld_sh_p0[0]) begin
        grant_p0   = DEST_BITS'((int'(rr_ptr_p0) + i) % N_ID);
        any_vld_p0 = 1'b1;
      end
    end
  end

  always_comb begin
    req_word_p0     = '0;
    bus.s_req_ready = '0;
    for (int i = 0; i < N_ID; i++) begin
      if (grant_p0 == DEST_BITS'(i)) begin
        req_word_p0        = bus.s_req_data[i];
        bus.s_req_ready[i] = acc_p0;
      end
    end
  end

  assign out_free_p0 = !vld_p1 || bus.m_req_ready;
  assign acc_p0      = any_vld_p0 && out_free_p0 && !cmd_full && !areset;
  assign next_ptr_p0 = DEST_BITS'((int'(grant_p0) + 1) % N_ID);

  always_comb begin
    cmd_p0.len  = req_word_p0[LEN_OFFS +: LEN_BITS];
    cmd_p0.dest = grant_p0;
  end

  // Zero-length requests are swallowed: the data mux beat counter cannot take len 0.
  assign push_p0 = acc_p0 && (cmd_p0.len != '0);

  user_cmd_fifo #(
    .WIDTH (MUX_CMD_BITS),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (aclk),
    .rst       (areset),
    .push      (push_p0),
    .push_data (cmd_p0),
    .pop       (bus.m_mux_ready),
    .pop_data  (bus.m_mux_data),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (bus.m_cmd_used)
  );

  assign bus.m_mux_valid = !cmd_empty;

  // Stage p1: output request register, held stable while the host stalls.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_p1  <= ST_IDLE;
      vld_p1    <= 1'b0;
      rr_ptr_p0 <= '0;
    end else begin
      if (acc_p0) rr_ptr_p0 <= next_ptr_p0;
      case (state_p1)
        ST_IDLE: begin
          if (push_p0) begin
            state_p1 <= ST_HOLD;
            vld_p1   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.m_req_ready && !push_p0) begin
            state_p1 <= ST_IDLE;
            vld_p1   <= 1'b0;
          end
        end
        default: begin
          state_p1 <= ST_IDLE;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push_p0) req_data_p1 <= req_word_p0;
  end

  assign bus.m_req_valid = vld_p1;
  assign bus.m_req_data  = req_data_p1;

endmodule

// File: tb/tb_user_arb_wr_req.sv
// Bench for user_arb_wr_req: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a queue-based reference model.
module tb_user_arb_wr_req;
  import user_arb_wr_req_pkg::*;

  localparam int N  = 4;
  localparam int RB = 96;
  localparam int LO = 48;
  localparam int CD = 4;

  logic aclk = 1'b0;
  logic areset;

  user_arb_wr_req_if #(.N_ID(N), .REQ_BITS(RB), .CMD_DEPTH(CD)) bus ();

  user_arb_wr_req #(
    .N_ID(N), .REQ_BITS(RB), .LEN_OFFS(LO), .CMD_DEPTH(CD)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  bit                       mdl_vld;
  logic [RB-1:0]            mdl_data;
  logic [MUX_CMD_BITS-1:0]  mdl_q[$];
  int                       mdl_rr;
  logic [N-1:0]             mdl_last_rdy;

  logic [MUX_CMD_BITS-1:0]  popped[$];
  logic [RB-1:0]            w;
  logic [RB-1:0]            wa [N];
  int                       acc_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [RB-1:0] mk_word(input int src, input int len, input int tag);
    logic [RB-1:0] r;
    r = '0;
    r[31:0]             = 32'(tag) ^ 32'h5A00_0000;
    r[47:32]            = 16'(src);
    r[LO +: LEN_BITS]   = LEN_BITS'(len);
    r[95:80]            = 16'hBEEF;
    return r;
  endfunction

  function automatic logic [127:0] mk_cmd(input int len, input int dest);
    logic [MUX_CMD_BITS-1:0] c;
    c = {LEN_BITS'(len), DEST_BITS'(dest)};
    return 128'(c);
  endfunction

  // Compare DUT against the model for the current inputs, then advance the model one edge.
  task automatic tick();
    int g;
    bit any;
    bit acc;
    logic [N-1:0] exp_rdy;
    logic [LEN_BITS-1:0] len;
    logic [RB-1:0] word;
    #1;
    any = 1'b0;
    g = 0;
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (mdl_rr + i) % N;
      if (!any && bus.s_req_valid[idx]) begin
        any = 1'b1;
        g = idx;
      end
    end
    word = bus.s_req_data[g];
    len  = word[LO +: LEN_BITS];
    acc  = any && (!mdl_vld || bus.m_req_ready) && (mdl_q.size() < CD) && !areset;
    exp_rdy = acc ? N'(1 << g) : '0;

    check("s_req_ready", 128'(bus.s_req_ready), 128'(exp_rdy));
    check("m_req_valid", 128'(bus.m_req_valid), 128'(mdl_vld));
    if (mdl_vld) check("m_req_data", 128'(bus.m_req_data), 128'(mdl_data));
    check("m_mux_valid", 128'(bus.m_mux_valid), 128'(mdl_q.size() != 0));
    if (mdl_q.size() != 0) check("m_mux_data", 128'(bus.m_mux_data), 128'(mdl_q[0]));
    check("m_cmd_used", 128'(bus.m_cmd_used), 128'(mdl_q.size()));

    if (bus.m_mux_valid && bus.m_mux_ready) popped.push_back(bus.m_mux_data);
    mdl_last_rdy = exp_rdy;

    if (areset) begin
      mdl_vld = 1'b0;
      mdl_q.delete();
      mdl_rr = 0;
    end else begin
      if (mdl_q.size() != 0 && bus.m_mux_ready) void'(mdl_q.pop_front());
      if (acc && len != 0) begin
        mdl_q.push_back({len, DEST_BITS'(g)});
        mdl_vld  = 1'b1;
        mdl_data = word;
      end else if (bus.m_req_ready) begin
        mdl_vld = 1'b0;
      end
      if (acc) mdl_rr = (g + 1) % N;
    end
    @(negedge aclk);
  endtask

  task automatic set_req(input int s, input logic [RB-1:0] d);
    bus.s_req_valid[s] = 1'b1;
    bus.s_req_data[s]  = d;
  endtask

  task automatic clear_reqs();
    bus.s_req_valid = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    areset = 1'b1;
    tick();
    areset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset          = 1'b1;
    bus.s_req_valid = '0;
    bus.s_req_data  = '0;
    bus.m_req_ready = 1'b0;
    bus.m_mux_ready = 1'b0;
    mdl_vld = 1'b0; mdl_data = '0; mdl_rr = 0; mdl_last_rdy = '0;
    @(negedge aclk);

    // Reset state, and no ready while reset is asserted
    check("rst m_req_valid", 128'(bus.m_req_valid), 128'(0));
    check("rst m_mux_valid", 128'(bus.m_mux_valid), 128'(0));
    check("rst m_cmd_used", 128'(bus.m_cmd_used), 128'(0));
    bus.s_req_valid = 4'hF;
    #1 check("rst s_req_ready", 128'(bus.s_req_ready), 128'(0));
    tick();
    areset = 1'b0;
    clear_reqs();

    // Single request from source 2
    bus.m_req_ready = 1'b1;
    bus.m_mux_ready = 1'b0;
    w = mk_word(2, 256, 1);
    set_req(2, w);
    #1 check("t1 ready", 128'(bus.s_req_ready), 128'(4'b0100));
    tick();
    clear_reqs();
    check("t1 m_req_valid", 128'(bus.m_req_valid), 128'(1));
    check("t1 m_req_data", 128'(bus.m_req_data), 128'(w));
    check("t1 mux_data", 128'(bus.m_mux_data), mk_cmd(256, 2));
    check("t1 used", 128'(bus.m_cmd_used), 128'(1));
    bus.m_mux_ready = 1'b1;
    tick();
    check("t1 drained", 128'(bus.m_cmd_used), 128'(0));

    // Fairness with all sources valid
    do_reset();
    bus.m_req_ready = 1'b1;
    bus.m_mux_ready = 1'b1;
    for (int s = 0; s < N; s++) set_req(s, mk_word(s, 64, 10 + s));
    popped.delete();
    for (int k = 0; k < 8; k++) begin
      #1 check("t2 grant", 128'(bus.s_req_ready), 128'(1 << (k % 4)));
      tick();
    end
    clear_reqs();
    repeat (3) tick();
    check("t2 n_cmds", 128'(popped.size()), 128'(8));
    for (int k = 0; k < 8; k++) begin
      if (k < popped.size()) check("t2 cmd order", 128'(popped[k]), mk_cmd(64, k % 4));
    end

    // Backpressure on the merged request
    do_reset();
    bus.m_req_ready = 1'b0;
    bus.m_mux_ready = 1'b0;
    w = mk_word(1, 32, 20);
    set_req(1, w);
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 0) check("t3 first ready", 128'(bus.s_req_ready), 128'(4'b0010));
      else begin
        check("t3 no ready", 128'(bus.s_req_ready), 128'(0));
        check("t3 data stable", 128'(bus.m_req_data), 128'(w));
      end
      tick();
    end
    check("t3 used", 128'(bus.m_cmd_used), 128'(1));
    clear_reqs();
    bus.m_req_ready = 1'b1;
    tick();

    // Command FIFO full, then pop with a request pending
    do_reset();
    bus.m_req_ready = 1'b1;
    bus.m_mux_ready = 1'b0;
    acc_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      set_req(0, mk_word(0, 16, 30 + k));
      #1 if (bus.s_req_ready[0]) acc_cnt++;
      tick();
    end
    check("t4 accepted", 128'(acc_cnt), 128'(4));
    check("t4 used full", 128'(bus.m_cmd_used), 128'(4));
    bus.m_mux_ready = 1'b1;
    #1 check("t4 no push on pop", 128'(bus.s_req_ready), 128'(0));
    tick();
    bus.m_mux_ready = 1'b0;
    #1 check("t4 push after pop", 128'(bus.s_req_ready), 128'(4'b0001));
    check("t4 used after pop", 128'(bus.m_cmd_used), 128'(3));
    tick();
    check("t4 refilled", 128'(bus.m_cmd_used), 128'(4));
    clear_reqs();

    // Zero-length request is consumed silently
    do_reset();
    bus.m_req_ready = 1'b1;
    bus.m_mux_ready = 1'b0;
    set_req(3, mk_word(3, 0, 40));
    #1 check("t5 zero ready", 128'(bus.s_req_ready), 128'(4'b1000));
    tick();
    clear_reqs();
    check("t5 no m_req", 128'(bus.m_req_valid), 128'(0));
    check("t5 no cmd", 128'(bus.m_cmd_used), 128'(0));
    w = mk_word(0, 128, 41);
    set_req(0, w);
    #1 check("t5 src0 ready", 128'(bus.s_req_ready), 128'(4'b0001));
    tick();
    clear_reqs();
    check("t5 m_req_valid", 128'(bus.m_req_valid), 128'(1));
    check("t5 m_req_data", 128'(bus.m_req_data), 128'(w));
    check("t5 cmd", 128'(bus.m_mux_data), mk_cmd(128, 0));
    check("t5 used", 128'(bus.m_cmd_used), 128'(1));

    // Reset in the middle of operation
    do_reset();
    bus.m_req_ready = 1'b1;
    bus.m_mux_ready = 1'b0;
    for (int s = 1; s < N; s++) set_req(s, mk_word(s, 8 * s, 50 + s));
    repeat (3) tick();
    bus.m_req_ready = 1'b0;
    check("t6 used", 128'(bus.m_cmd_used), 128'(3));
    check("t6 held", 128'(bus.m_req_valid), 128'(1));
    tick();
    areset = 1'b1;
    #1 check("t6 rst ready", 128'(bus.s_req_ready), 128'(0));
    tick();
    areset = 1'b0;
    check("t6 m_req_valid", 128'(bus.m_req_valid), 128'(0));
    check("t6 m_mux_valid", 128'(bus.m_mux_valid), 128'(0));
    check("t6 used clr", 128'(bus.m_cmd_used), 128'(0));
    clear_reqs();
    set_req(0, mk_word(0, 5, 60));
    set_req(2, mk_word(2, 6, 61));
    bus.m_req_ready = 1'b1;
    #1 check("t6 grant src0", 128'(bus.s_req_ready), 128'(4'b0001));
    tick();
    clear_reqs();
    repeat (2) tick();

    // Randomized traffic; sources hold a request until it is accepted
    for (int c = 0; c < 3000; c++) begin
      for (int s = 0; s < N; s++) begin
        if (!bus.s_req_valid[s] || mdl_last_rdy[s]) begin
          if ($urandom_range(0, 2) != 0) begin
            wa[s] = {$urandom, $urandom, $urandom};
            wa[s][LO +: LEN_BITS] = ($urandom_range(0, 5) == 0) ? '0
                                    : LEN_BITS'($urandom_range(1, 4096));
            set_req(s, wa[s]);
          end else begin
            bus.s_req_valid[s] = 1'b0;
          end
        end
      end
      bus.m_req_ready = ($urandom_range(0, 9) < 7);
      bus.m_mux_ready = ($urandom_range(0, 1) == 1);
      areset          = ($urandom_range(0, 299) == 0);
      tick();
    end
    areset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
